// File: rtl/fc_sequencer.sv
// Forward/backward propagation sequencer for a chain of fc layers.
// Strobes one layer at a time, generates the shared oscillator and reports busy/done.
//
// state  | meaning
// IDLE   | waiting for start_in; all outputs low
// FWD    | fd_prop strobe on the active layer, walking layer 0 -> last
// BWD    | bk_prop strobe on the active layer, walking last -> layer 0
// DONE   | single-cycle done pulse, busy still high
module fc_sequencer #(
  parameter int NUM_LAYERS = 3,
  parameter int FD_CYCLES  = 4,
  parameter int BK_CYCLES  = 2,
  parameter int OSC_DIV    = 1,
  localparam int LW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  start_in,
  input  logic                  train_in,
  input  logic                  abort_in,
  output logic [NUM_LAYERS-1:0] fd_prop_out,
  output logic [NUM_LAYERS-1:0] bk_prop_out,
  output logic                  oscillator_out,
  output logic [LW-1:0]         layer_out,
  output logic                  busy_out,
  output logic                  done_out
);

  localparam int CMAX = (FD_CYCLES > BK_CYCLES) ? FD_CYCLES : BK_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int DW   = (OSC_DIV > 1) ? $clog2(OSC_DIV) : 1;

  localparam logic [CW-1:0] FD_LOAD   = CW'(FD_CYCLES - 1);
  localparam logic [CW-1:0] BK_LOAD   = CW'(BK_CYCLES - 1);
  localparam logic [DW-1:0] DIV_LOAD  = DW'(OSC_DIV - 1);
  localparam logic [LW-1:0] LAST_LYR  = LW'(NUM_LAYERS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FWD  = 2'd1,
    S_BWD  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [LW-1:0]         r_layer;
  logic [LW-1:0]         w_layer_nxt;
  logic [CW-1:0]         r_cnt;
  logic [CW-1:0]         w_cnt_nxt;
  logic                  r_train;
  logic                  w_train_nxt;
  logic [DW-1:0]         r_div;
  logic [DW-1:0]         w_div_nxt;
  logic                  r_osc;
  logic                  w_osc_nxt;
  logic [NUM_LAYERS-1:0] r_fd;
  logic [NUM_LAYERS-1:0] w_fd_nxt;
  logic [NUM_LAYERS-1:0] r_bk;
  logic [NUM_LAYERS-1:0] w_bk_nxt;
  logic                  r_busy;
  logic                  w_busy_nxt;
  logic                  r_done;
  logic                  w_done_nxt;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= S_IDLE;
      r_layer <= '0;
      r_cnt   <= '0;
      r_train <= 1'b0;
      r_div   <= '0;
      r_osc   <= 1'b0;
      r_fd    <= '0;
      r_bk    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_layer <= w_layer_nxt;
      r_cnt   <= w_cnt_nxt;
      r_train <= w_train_nxt;
      r_div   <= w_div_nxt;
      r_osc   <= w_osc_nxt;
      r_fd    <= w_fd_nxt;
      r_bk    <= w_bk_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_layer_nxt = r_layer;
    w_cnt_nxt   = r_cnt;
    w_train_nxt = r_train;
    w_div_nxt   = r_div;
    w_osc_nxt   = r_osc;

    case (r_state)
      S_IDLE: begin
        if (start_in) begin
          w_train_nxt = train_in;
          w_layer_nxt = '0;
          w_cnt_nxt   = FD_LOAD;
          w_state_nxt = S_FWD;
        end
      end
      S_FWD: begin
        if (r_cnt == '0) begin
          if (r_layer == LAST_LYR) begin
            if (r_train) begin
              w_cnt_nxt   = BK_LOAD;
              w_state_nxt = S_BWD;
            end else begin
              w_state_nxt = S_DONE;
            end
          end else begin
            w_layer_nxt = r_layer + LW'(1);
            w_cnt_nxt   = FD_LOAD;
          end
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      S_BWD: begin
        if (r_cnt == '0) begin
          if (r_layer == '0) begin
            w_state_nxt = S_DONE;
          end else begin
            w_layer_nxt = r_layer - LW'(1);
            w_cnt_nxt   = BK_LOAD;
          end
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // abort wins over every transition taken above
    if (abort_in && (r_state != S_IDLE)) begin
      w_state_nxt = S_IDLE;
    end

    if (w_state_nxt == S_IDLE) begin
      w_layer_nxt = '0;
      w_cnt_nxt   = '0;
      w_train_nxt = 1'b0;
    end

    if (w_state_nxt == S_IDLE) begin
      w_osc_nxt = 1'b0;
      w_div_nxt = '0;
    end else if (r_state == S_IDLE) begin
      w_osc_nxt = 1'b0;
      w_div_nxt = DIV_LOAD;
    end else if (r_div == '0) begin
      w_osc_nxt = ~r_osc;
      w_div_nxt = DIV_LOAD;
    end else begin
      w_div_nxt = r_div - DW'(1);
    end

    w_fd_nxt   = (w_state_nxt == S_FWD) ? (NUM_LAYERS'(1) << w_layer_nxt) : '0;
    w_bk_nxt   = (w_state_nxt == S_BWD) ? (NUM_LAYERS'(1) << w_layer_nxt) : '0;
    w_busy_nxt = (w_state_nxt != S_IDLE);
    w_done_nxt = (w_state_nxt == S_DONE);
  end

  assign fd_prop_out    = r_fd;
  assign bk_prop_out    = r_bk;
  assign oscillator_out = r_osc;
  assign layer_out      = r_layer;
  assign busy_out       = r_busy;
  assign done_out       = r_done;

endmodule

// File: tb/tb_fc_sequencer.sv
// Scoreboard bench for fc_sequencer: stimulus pushes the expected per-cycle outputs,
// a monitor pops and compares one entry after every clock edge.
module tb_fc_sequencer;

  logic       clk_in   = 1'b0;
  logic       rst_in   = 1'b0;
  logic       start_in = 1'b0;
  logic       train_in = 1'b0;
  logic       abort_in = 1'b0;

  logic [2:0] fd_a, bk_a, fd_b, bk_b;
  logic [1:0] lay_a, lay_b;
  logic       osc_a, osc_b, busy_a, busy_b, done_a, done_b;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [2:0] fd;
    logic [2:0] bk;
    logic [1:0] layer;
    logic       busy;
    logic       done;
    logic       osc1;
    logic       osc2;
  } exp_t;

  exp_t q[$];

  always #5 clk_in = ~clk_in;

  fc_sequencer #(.NUM_LAYERS(3), .FD_CYCLES(4), .BK_CYCLES(2), .OSC_DIV(1)) u_dut_a (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .train_in(train_in),
    .abort_in(abort_in), .fd_prop_out(fd_a), .bk_prop_out(bk_a),
    .oscillator_out(osc_a), .layer_out(lay_a), .busy_out(busy_a), .done_out(done_a)
  );

  fc_sequencer #(.NUM_LAYERS(3), .FD_CYCLES(4), .BK_CYCLES(2), .OSC_DIV(2)) u_dut_b (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .train_in(train_in),
    .abort_in(abort_in), .fd_prop_out(fd_b), .bk_prop_out(bk_b),
    .oscillator_out(osc_b), .layer_out(lay_b), .busy_out(busy_b), .done_out(done_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Hand-derived timeline for the default configuration; k = cycles after the start edge.
  function automatic exp_t exp_at(input int k, input bit tr, input int abort_at);
    exp_t e;
    int   done_k;
    e      = '0;
    done_k = tr ? 19 : 13;
    if (abort_at > 0 && k > abort_at) return e;
    if (k >= 1 && k <= 12) begin
      e.fd    = 3'(1 << ((k - 1) / 4));
      e.layer = 2'((k - 1) / 4);
      e.busy  = 1'b1;
    end else if (tr && k >= 13 && k <= 18) begin
      e.bk    = 3'(1 << (2 - (k - 13) / 2));
      e.layer = 2'(2 - (k - 13) / 2);
      e.busy  = 1'b1;
    end else if (k == done_k) begin
      e.done  = 1'b1;
      e.busy  = 1'b1;
      e.layer = tr ? 2'd0 : 2'd2;
    end
    if (e.busy) begin
      e.osc1 = 1'(((k - 1) / 1) % 2);
      e.osc2 = 1'(((k - 1) / 2) % 2);
    end
    return e;
  endfunction

  initial begin
    forever begin
      @(posedge clk_in);
      #1;
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        check("fd_prop",    32'(fd_a),   32'(e.fd));
        check("bk_prop",    32'(bk_a),   32'(e.bk));
        check("layer",      32'(lay_a),  32'(e.layer));
        check("busy",       32'(busy_a), 32'(e.busy));
        check("done",       32'(done_a), 32'(e.done));
        check("osc_div1",   32'(osc_a),  32'(e.osc1));
        check("osc_div2",   32'(osc_b),  32'(e.osc2));
        check("fd_prop_b",  32'(fd_b),   32'(e.fd));
        check("bk_prop_b",  32'(bk_b),   32'(e.bk));
        check("done_b",     32'(done_b), 32'(e.done));
        check("onehot",     32'($countones({fd_a | bk_a}) <= 1), 32'(1));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk_in);
      start_in = 1'b0;
      abort_in = 1'b0;
      train_in = 1'b0;
      q.push_back('0);
    end
  endtask

  task automatic run_step(input bit tr, input int abort_at, input int p1, input int p2,
                          input bit abort0);
    int last;
    last = (abort_at > 0) ? abort_at + 1 : (tr ? 20 : 14);
    @(negedge clk_in);
    start_in = 1'b1;
    train_in = tr;
    abort_in = abort0;
    q.push_back(exp_at(1, tr, abort_at));
    for (int k = 1; k < last; k++) begin
      @(negedge clk_in);
      start_in = (k == p1) || (k == p2);
      train_in = ~tr;
      abort_in = (k == abort_at);
      q.push_back(exp_at(k + 1, tr, abort_at));
    end
    @(negedge clk_in);
    start_in = 1'b0;
    abort_in = 1'b0;
    train_in = 1'b0;
    q.push_back('0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_fd"},   32'(fd_a),   32'(0));
    check({tag, "_bk"},   32'(bk_a),   32'(0));
    check({tag, "_layer"},32'(lay_a),  32'(0));
    check({tag, "_busy"}, 32'(busy_a), 32'(0));
    check({tag, "_done"}, 32'(done_a), 32'(0));
    check({tag, "_osc"},  32'(osc_a),  32'(0));
    check({tag, "_osc_b"},32'(osc_b),  32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, queue depth %0d", q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    check_reset_outputs("por");
    @(negedge clk_in);
    rst_in = 1'b1;
    idle(2);

    run_step(1'b0, 0, 0, 0, 1'b0);   // forward-only
    idle(2);
    run_step(1'b1, 0, 0, 0, 1'b0);   // training
    idle(2);
    run_step(1'b0, 0, 5, 13, 1'b0);  // start pulses while busy are ignored
    idle(1);
    run_step(1'b1, 15, 0, 0, 1'b0);  // abort during backward pass
    idle(2);
    run_step(1'b0, 0, 0, 0, 1'b0);   // fresh step after abort
    idle(1);
    run_step(1'b0, 6, 0, 0, 1'b0);   // abort during forward pass
    idle(1);
    run_step(1'b1, 0, 0, 0, 1'b1);   // abort with start in IDLE: start wins
    idle(2);

    // asynchronous reset in the middle of the forward pass
    @(negedge clk_in);
    start_in = 1'b1;
    train_in = 1'b1;
    q.push_back(exp_at(1, 1'b1, 0));
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk_in);
      start_in = 1'b0;
      q.push_back(exp_at(k + 1, 1'b1, 0));
    end
    @(negedge clk_in);
    #2;
    rst_in = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(negedge clk_in);
    rst_in = 1'b1;
    idle(3);
    run_step(1'b0, 0, 0, 0, 1'b0);
    idle(2);

    @(posedge clk_in);
    #2;
    check("queue_drained", 32'(q.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
